// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared widths, access-size encoding and FSM states for the load/store unit
package load_store_unit_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } MemSize;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        RMW_RD,
        RMW_WR,
        WR,
        ERR
    } LsuState;

    // Reserved size or an access that straddles its natural alignment.
    function automatic logic isBadAccess(input MemSize size, input logic [1:0] addrLow);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addrLow[0];
            SIZE_WORD: return addrLow != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - little-endian lane extraction, load extension and sub-word store merge
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [1:0]            addrLow,
    input  MemSize                size,
    input  logic                  isSigned,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [15:0]           storeData,
    output logic [DATA_WIDTH-1:0] loadData,
    output logic [DATA_WIDTH-1:0] mergeData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    int          byteSel;
    int          halfSel;

    always_comb begin
        byteSel  = 8 * int'(addrLow);
        halfSel  = 16 * int'(addrLow[1]);
        byteLane = rdata[byteSel +: 8];
        halfLane = rdata[halfSel +: 16];

        case (size)
            SIZE_BYTE: loadData = {{(DATA_WIDTH-8){isSigned & byteLane[7]}}, byteLane};
            SIZE_HALF: loadData = {{(DATA_WIDTH-16){isSigned & halfLane[15]}}, halfLane};
            default:   loadData = rdata;
        endcase

        mergeData = rdata;
        case (size)
            SIZE_BYTE: mergeData[byteSel +: 8]  = storeData[7:0];
            SIZE_HALF: mergeData[halfSel +: 16] = storeData;
            default:   ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with read-modify-write for sub-word stores
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    LsuState               state;
    LsuState               nextState;
    MemSize                reqSize;
    MemSize                capSize;
    logic                  capSigned;
    logic [ADDR_WIDTH-1:0] capAddr;
    logic [DATA_WIDTH-1:0] capWdata;
    logic                  accept;
    logic                  reqErr;
    logic                  memActive;
    logic                  respValidNext;
    logic                  respErrNext;
    logic [DATA_WIDTH-1:0] respDataNext;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] mergeData;

    assign reqSize   = MemSize'(req_size);
    assign reqErr    = isBadAccess(reqSize, req_addr[1:0]);
    assign req_ready = rst && (state == IDLE);
    assign accept    = req_valid && req_ready;

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) align (
        .addrLow  (capAddr[1:0]),
        .size     (capSize),
        .isSigned (capSigned),
        .rdata    (mem_rdata),
        .storeData(capWdata[15:0]),
        .loadData (loadData),
        .mergeData(mergeData)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= nextState;
            resp_valid <= respValidNext;
            resp_err   <= respErrNext;
            resp_rdata <= respDataNext;
            if (accept) begin
                capSize   <= reqSize;
                capSigned <= req_signed;
                capAddr   <= req_addr;
                capWdata  <= req_wdata;
            end
        end
    end

    // The response is registered on the edge that returns to IDLE.
    always_comb begin
        nextState     = state;
        respValidNext = 1'b0;
        respErrNext   = 1'b0;
        respDataNext  = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reqErr)                   nextState = ERR;
                    else if (!req_we)             nextState = RD_ADDR;
                    else if (reqSize == SIZE_WORD) nextState = WR;
                    else                          nextState = RMW_RD;
                end
            end
            RD_ADDR: nextState = RD_DATA;
            RD_DATA: begin
                nextState     = IDLE;
                respValidNext = 1'b1;
                respDataNext  = loadData;
            end
            RMW_RD: nextState = RMW_WR;
            RMW_WR, WR: begin
                nextState     = IDLE;
                respValidNext = 1'b1;
            end
            ERR: begin
                nextState     = IDLE;
                respValidNext = 1'b1;
                respErrNext   = 1'b1;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        memActive = 1'b0;
        case (state)
            RD_ADDR, RD_DATA, RMW_RD, RMW_WR, WR: memActive = 1'b1;
            default: memActive = 1'b0;
        endcase
    end

    assign mem_addr = memActive ? {capAddr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_we   = rst && ((state == WR) || (state == RMW_WR));

    always_comb begin
        mem_wdata = '0;
        if (mem_we) mem_wdata = (state == WR) ? capWdata : mergeData;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a word-array memory model
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } Req;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem    [64];
    logic [31:0] refMem [64];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic Req mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
        Req r;
        r.we = we; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic drive(input Req r);
        req_we = r.we; req_size = r.size; req_signed = r.sgn;
        req_addr = r.addr; req_wdata = r.wdata; req_valid = 1'b1;
    endtask

    // Reference behaviour: memory is an array of words, lanes are shifts and masks.
    task automatic model(input Req r, output int lat, output logic err, output logic [31:0] rdata,
                         output int nWr, output logic [31:0] wAddr, output logic [31:0] wWord);
        int w;
        int sft;
        logic [31:0] old;
        logic [31:0] sh;
        logic [31:0] mask;
        w     = int'(r.addr[7:2]);
        sft   = 8 * int'(r.addr[1:0]);
        old   = refMem[w];
        err   = (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) || (r.size == 2'd2 && r.addr[1:0] != 2'd0);
        rdata = 32'd0; nWr = 0; wWord = 32'd0;
        wAddr = {r.addr[31:2], 2'b00};
        if (err) begin
            lat = 2;
        end else if (!r.we) begin
            lat = 3;
            sh  = old >> sft;
            if (r.size == 2'd0) begin
                rdata = sh & 32'hFF;
                if (r.sgn && rdata[7]) rdata = rdata | 32'hFFFF_FF00;
            end else if (r.size == 2'd1) begin
                rdata = sh & 32'hFFFF;
                if (r.sgn && rdata[15]) rdata = rdata | 32'hFFFF_0000;
            end else begin
                rdata = old;
            end
        end else begin
            nWr = 1;
            if (r.size == 2'd2) begin
                lat   = 2;
                wWord = r.wdata;
            end else begin
                lat   = 3;
                mask  = ((r.size == 2'd0) ? 32'hFF : 32'hFFFF) << sft;
                wWord = (old & ~mask) | ((r.wdata << sft) & mask);
            end
            refMem[w] = wWord;
        end
    endtask

    // hold=1 presents the next request right after acceptance and keeps req_valid high.
    task automatic runReqs(input Req q[$], input bit hold, input int gap);
        int idx = 0, age = 0, lat = 0, nWr = 0, wrSeen = 0, waitGap = 0, cyc = 0;
        bit pending = 0, presented = 0, justAcc = 0;
        logic expErr;
        logic [31:0] expData, wAddr, wWord;
        while ((idx < q.size() || pending) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (justAcc) begin
                justAcc = 0; req_valid = 1'b0; waitGap = gap;
                if (hold && idx < q.size()) begin drive(q[idx]); presented = 1; end
            end else if (!presented && idx < q.size()) begin
                if (waitGap > 0) waitGap--;
                else begin drive(q[idx]); presented = 1; end
            end
            if (pending) begin
                age++;
                if (mem_we) begin
                    wrSeen++;
                    chk("mem_addr", mem_addr, wAddr);
                    chk("mem_wdata", mem_wdata, wWord);
                end
                if (resp_valid) begin
                    chk("latency", age, lat);
                    chk("resp_err", 32'(resp_err), 32'(expErr));
                    chk("resp_rdata", resp_rdata, expData);
                    chk("write_count", wrSeen, nWr);
                    chk("ready_after_resp", 32'(req_ready), 32'd1);
                    pending = 0;
                end else if (age >= lat) begin
                    chk("resp_missing", 32'(resp_valid), 32'd1);
                    pending = 0;
                end else begin
                    chk("ready_busy", 32'(req_ready), 32'd0);
                end
            end else begin
                chk("idle_no_resp", 32'(resp_valid), 32'd0);
                chk("idle_no_we", 32'(mem_we), 32'd0);
                if (presented) chk("ready_idle", 32'(req_ready), 32'd1);
            end
            if (presented && req_ready && !pending) begin
                model(q[idx], lat, expErr, expData, nWr, wAddr, wWord);
                pending = 1; age = 0; wrSeen = 0; presented = 0; justAcc = 1; idx++;
            end
        end
        chk("run_complete", 32'(idx < q.size() || pending), 32'd0);
        req_valid = 1'b0;
    endtask

    task automatic resetDuring(input int stopAge, input Req r);
        drive(r);
        @(posedge clk);
        for (int i = 0; i < stopAge; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(resp_valid), 32'd0);
            chk("rst_no_we", 32'(mem_we), 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("ready_after_release", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        Req q[$];
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) refMem[i] = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_first_cycle", 32'(req_ready), 32'd1);

        q = {};
        for (int i = 0; i < 64; i++) q.push_back(mk(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom));
        runReqs(q, 1'b1, 0);

        q = {};
        q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0));
        q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344));
        q.push_back(mk(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0));
        q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h30, 32'h0000F080));
        q.push_back(mk(1'b0, 2'd0, 1'b1, 32'h30, 32'h0));
        q.push_back(mk(1'b0, 2'd1, 1'b0, 32'h30, 32'h0));
        q.push_back(mk(1'b0, 2'd1, 1'b1, 32'h30, 32'h0));
        q.push_back(mk(1'b0, 2'd1, 1'b0, 32'h31, 32'h0));
        q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h32, 32'h12345678));
        q.push_back(mk(1'b0, 2'd3, 1'b0, 32'h00, 32'h0));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h30, 32'h0));
        runReqs(q, 1'b0, 1);

        resetDuring(1, mk(1'b1, 2'd0, 1'b0, 32'h41, 32'h000000C3));
        resetDuring(2, mk(1'b1, 2'd1, 1'b0, 32'h46, 32'h0000BEEF));
        q = {};
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h40, 32'h0));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h44, 32'h0));
        runReqs(q, 1'b0, 0);

        for (int pass = 0; pass < 2; pass++) begin
            q = {};
            for (int i = 0; i < 40; i++)
                q.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                               32'($urandom_range(0, 255)), $urandom));
            runReqs(q, pass == 0, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
